// File: rtl/tap_block_loader.sv
// Lynx TAP image loader: parses quoted-name blocks from the ioctl stream and writes payloads to RAM.
// Optional TAP_FORCED_LOAD_EN: ignore header load address and load every block at FORCED_LOAD.
module tap_block_loader #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned LEN_ADJ     = 0,
  parameter logic [7:0]  MARK        = 8'h22,
  parameter logic [15:0] FORCED_LOAD = 16'h694D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [7:0]        file_type,
  output logic [ADDR_W-1:0] exec_addr,
  output logic [7:0]        block_count,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_NAME, S_TYPE, S_LEN_LO, S_LEN_HI, S_LOAD_LO, S_LOAD_HI,
    S_EXEC_LO, S_EXEC_HI, S_DATA, S_CHECK, S_TRAIL, S_ERR
  } state_e;

  state_e            state_q;
  logic              dl_q;
  logic [7:0]        len_lo_q;
  logic [7:0]        exec_lo_q;
  logic [7:0]        sum_q;
  logic [LEN_W-1:0]  count_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic [7:0]        file_type_q;
  logic [ADDR_W-1:0] exec_addr_q;
  logic [7:0]        block_count_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        err_code_q;

  logic              dl_rise;
  logic              dl_fall;
  logic              accept;
  logic [LEN_W-1:0]  count_d;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] exec_addr_d;
  logic              unused_ioctl_addr;

  assign unused_ioctl_addr = ^ioctl_addr;

  assign ioctl_wait = mem_wr_q && !mem_ready;
  assign dl_rise    = ioctl_download && !dl_q;
  assign dl_fall    = !ioctl_download && dl_q;
  assign accept     = ioctl_download && ioctl_wr && !ioctl_wait;

  assign count_d     = LEN_W'({ioctl_dout, len_lo_q}) - LEN_W'(LEN_ADJ);
  assign exec_addr_d = ADDR_W'({ioctl_dout, exec_lo_q});

`ifdef TAP_FORCED_LOAD_EN
  assign ptr_d = ADDR_W'(FORCED_LOAD);
`else
  logic [7:0] load_lo_q;
  assign ptr_d = ADDR_W'({ioctl_dout, load_lo_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_lo_q <= '0;
    end else if (accept && !dl_rise && state_q == S_LOAD_LO) begin
      load_lo_q <= ioctl_dout;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      dl_q          <= 1'b0;
      len_lo_q      <= '0;
      exec_lo_q     <= '0;
      sum_q         <= '0;
      count_q       <= '0;
      ptr_q         <= '0;
      mem_addr_q    <= '0;
      mem_dout_q    <= '0;
      mem_wr_q      <= 1'b0;
      file_type_q   <= '0;
      exec_addr_q   <= '0;
      block_count_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= '0;
    end else begin
      dl_q <= ioctl_download;

      // A pending write always retires on mem_ready, independent of download edges.
      if (mem_wr_q && mem_ready) begin
        mem_wr_q <= 1'b0;
      end

      if (dl_rise) begin
        done_q        <= 1'b0;
        error_q       <= 1'b0;
        err_code_q    <= '0;
        block_count_q <= '0;
        state_q       <= S_IDLE;
      end else if (dl_fall) begin
        if (state_q == S_IDLE) begin
          if (block_count_q != '0 && !error_q) begin
            done_q <= 1'b1;
          end
        end else if (state_q != S_ERR) begin
          error_q    <= 1'b1;
          err_code_q <= 2'd2;
          state_q    <= S_ERR;
        end
      end else if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (ioctl_dout == MARK) state_q <= S_NAME;
          end
          S_NAME: begin
            if (ioctl_dout == MARK) state_q <= S_TYPE;
          end
          S_TYPE: begin
            file_type_q <= ioctl_dout;
            state_q     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_lo_q <= ioctl_dout;
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            count_q <= count_d;
            state_q <= S_LOAD_LO;
          end
          S_LOAD_LO: begin
            state_q <= S_LOAD_HI;
          end
          S_LOAD_HI: begin
            ptr_q   <= ptr_d;
            state_q <= S_EXEC_LO;
          end
          S_EXEC_LO: begin
            exec_lo_q <= ioctl_dout;
            state_q   <= S_EXEC_HI;
          end
          S_EXEC_HI: begin
            exec_addr_q <= exec_addr_d;
            sum_q       <= '0;
            state_q     <= (count_q == '0) ? S_CHECK : S_DATA;
          end
          S_DATA: begin
            mem_addr_q <= ptr_q;
            mem_dout_q <= ioctl_dout;
            mem_wr_q   <= 1'b1;
            ptr_q      <= ptr_q + ADDR_W'(1);
            sum_q      <= sum_q + ioctl_dout;
            count_q    <= count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (ioctl_dout != sum_q) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd1;
              state_q    <= S_ERR;
            end else begin
              state_q <= S_TRAIL;
            end
          end
          S_TRAIL: begin
            if (block_count_q != 8'hFF) block_count_q <= block_count_q + 8'd1;
            state_q <= S_IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = mem_wr_q;
  assign file_type   = file_type_q;
  assign exec_addr   = exec_addr_q;
  assign block_count = block_count_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule

// File: doc/tap_block_loader.md
Name: tap_block_loader

Overview:
- Parametrised successor to the single-block cassette parser.
- Consumes a Lynx TAP image streamed over the ioctl download bus. Parses one or more quoted-name blocks and writes each payload into system RAM through a back-pressured write port.
- Verifies a per-block 8-bit checksum and reports completion, error cause, block count and the entry point to the machine core.
- Sits between the HPS ioctl interface and the RAM arbiter.

Parameters:
- ADDR_W, 16, width of RAM write address and load/exec pointers.
- LEN_W, 16, width of length field and data counter (header always carries 16 bits; zero-extended or truncated to LEN_W).
- LEN_ADJ, 0, constant subtracted from header length to obtain payload byte count.
- MARK, 8'h22, delimiter byte opening and closing the block name.
- FORCED_LOAD, 16'h694D, load address used when the optional feature is enabled.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  byte strobe
- ioctl_addr  in  25  byte offset in image, debug only
- ioctl_dout  in  8  image byte
- ioctl_wait  out  1  stall request to HPS
- mem_addr  out  ADDR_W  RAM write address
- mem_dout  out  8  RAM write data
- mem_wr  out  1  write request, held until accepted
- mem_ready  in  1  RAM accepts write this cycle
- file_type  out  8  type byte of last block
- exec_addr  out  ADDR_W  exec point of last block
- block_count  out  8  completed blocks, saturates at 255
- done  out  1  image fully loaded without error
- error  out  1  sticky error
- err_code  out  2  0 none, 1 checksum, 2 truncated, 3 reserved

Behaviour:
- Reset: all outputs 0, state IDLE.
- Byte acceptance: a byte is consumed only when ioctl_download && ioctl_wr && !ioctl_wait.
- Rising edge of ioctl_download:
  - clears done, error, err_code and block_count;
  - returns to IDLE.
  - This takes priority over any other event in the same cycle.
- States, one accepted byte per transition unless noted:
  - IDLE: skip bytes until MARK, then NAME.
  - NAME: skip bytes until MARK, then TYPE.
  - TYPE: latch file_type.
  - LEN_LO, LEN_HI: assemble length. At LEN_HI, count = length - LEN_ADJ, computed modulo 2^LEN_W.
  - LOAD_LO, LOAD_HI: assemble load pointer.
  - EXEC_LO, EXEC_HI: assemble exec_addr. At EXEC_HI, clear the running sum. Go to CHECK if count==0, else DATA.
  - DATA: each byte drives mem_addr=ptr, mem_dout=byte, mem_wr=1 on the next cycle. Then ptr+1 (wraps mod 2^ADDR_W), sum+=byte (mod 256), count-1. Last byte (count==1) -> CHECK.
  - CHECK: compare byte with sum. Mismatch -> error=1, err_code=1, ERR. Match -> TRAIL.
  - TRAIL: discard byte, block_count+1 (saturating), go to IDLE for the next block.
  - ERR: absorb all bytes, no writes.
- Back-pressure:
  - ioctl_wait = mem_wr && !mem_ready.
  - mem_wr drops the cycle after mem_ready is sampled high.
  - Address and data are stable while mem_wr is high.
- ioctl_download falling edge:
  - In IDLE with block_count>0 and no error -> done=1.
  - In any state from NAME to TRAIL -> error=1, err_code=2.
  - Otherwise no change.
  - Any pending mem_wr still completes.
- Reset mid-write: mem_wr drops immediately. The partial block is not counted.
- Latency: header byte to register 1 cycle; data byte to mem_wr 1 cycle.

Optional Feature:
- Macro: TAP_FORCED_LOAD_EN.
- Defined: LOAD_LO/LOAD_HI bytes are consumed but ignored, and ptr = FORCED_LOAD[ADDR_W-1:0].
- Undefined: ptr is taken from the header, little-endian.

Test Plan:
- Single block "AB", type 42, len 0003, load 6000, exec 6100, data 11 22 33, chk 66, trail 00; mem_ready=1; download falls -> writes 6000=11, 6001=22, 6002=33; exec_addr=6100; block_count=1; done=1.
- Same image, chk 00 -> error=1, err_code=1; no further writes; done=0.
- mem_ready held low 4 cycles on the 2nd data byte -> ioctl_wait high 4 cycles; mem_addr=6001/mem_dout=22 stable throughout; no byte lost.
- Two blocks back to back (loads 6000 and 7000, exec 6100 then 7100) -> block_count=2; exec_addr=7100; done=1.
- Download drops after LEN_HI -> error=1, err_code=2; new download rising edge clears both.
- Load FFFF, len 0002 -> writes FFFF and 0000 (wrap). With TAP_FORCED_LOAD_EN, the same image writes 694D and 694E.
